uart_msg_checker: RTL and testbench
===================================

// Module: uart_msg_checker
// PURPOSE
//  Receive-side counterpart of the periodic "Hello World!\n\r" UART sender.
//  Sits behind the osdvu uart receiver (received/rx_byte/recv_error) and checks
//  the incoming byte stream against the fixed 14-byte frame "Hello World!\n\r".
//  Counts good frames and errors; drives status for LEDs/debug.
// PARAMETERS
//  TIMEOUT_CYCLES  4194304  max clk cycles between bytes inside a frame (2x sender gap of 2^21)
//  CNT_W           8        width of match_count / err_count (saturating)
// PORTS
//  clk          in   1      system clock (12 MHz)
//  rst_n        in   1      asynchronous active-low reset
//  rx_valid     in   1      1-cycle pulse, rx_byte valid (uart .received)
//  rx_byte      in   8      received byte (uart .rx_byte)
//  rx_error     in   1      1-cycle pulse, framing error (uart .recv_error)
//  match        out  1      1-cycle pulse: complete frame received correctly
//  match_count  out  CNT_W  number of good frames, saturating
//  err_count    out  CNT_W  number of mismatches/rx errors/timeouts, saturating
//  in_frame     out  1      high while state == MATCH
//  last_bad     out  8      last byte that caused a mismatch
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, idx=0, timer=0, all outputs 0.
//  - Frame ROM: idx 0..13 = 'H','e','l','l','o',' ','W','o','r','l','d','!',8'h0A,8'h0D.
//  - States: IDLE, MATCH. All updates on posedge clk; outputs registered.
//  - IDLE: rx_valid && byte=='H' -> idx=1, MATCH. Other bytes ignored (no error).
//  - MATCH, rx_valid:
//     byte==rom[idx], idx<13 -> idx++, timer=0.
//     byte==rom[13] at idx==13 -> match=1 next cycle, match_count++, IDLE, idx=0.
//     mismatch -> err_count++, last_bad<=byte; byte=='H' -> idx=1 stay MATCH
//       (resync, timer=0), else IDLE, idx=0.
//  - MATCH, no rx_valid: timer++; timer reaches TIMEOUT_CYCLES-1 -> err_count++,
//    IDLE, idx=0, timer=0. last_bad unchanged.
//  - rx_error (any state): err_count++, IDLE, idx=0, timer=0; byte in same cycle
//    discarded (error wins over rx_valid).
//  - rx_valid and timeout expiry same cycle: byte wins, timeout not counted.
//  - Timer only runs in MATCH; held 0 in IDLE. Width = clog2(TIMEOUT_CYCLES)+1.
//  - Counters saturate at all-ones, never wrap. One increment per cycle max.
//  - match latency: asserted exactly 1 cycle after the rx_valid of byte 13;
//    high for exactly 1 cycle.
//  - in_frame = (state==MATCH), registered with state.
//  - Reset mid-frame: everything returns to reset values; next frame needs 'H'.
// TESTING (bench uses TIMEOUT_CYCLES=1000, CNT_W=4)
//  1 Send full 14-byte frame, 20 cycles apart -> one match pulse, match_count=1,
//    err_count=0, in_frame low after.
//  2 Send "Hellx" -> err_count=1, last_bad=8'h78, IDLE; then full frame -> match_count=1.
//  3 Send "HelH" then "ello World!\n\r" -> resync: err_count=1, match_count=1.
//  4 Send "Hel", wait 1000 cycles -> err_count=1, in_frame=0; byte at cycle 999 after
//    'l' instead -> no timeout.
//  5 rx_valid+rx_error same cycle mid-frame -> err_count+1, IDLE, no byte effect;
//    assert rst_n=0 mid-frame -> all outputs 0 immediately.
//  6 Send 20 good frames -> match_count saturates at 15; junk in IDLE -> err_count 0.

Source files
------------

// File: rtl/uart_msg_checker.sv
// Receive-side checker for the periodic "Hello World!\n\r" UART frame.
// Matches the incoming byte stream against the fixed 14-byte frame, counts
// good frames and errors (saturating), and exposes status for LEDs/debug.
module uart_msg_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 4194304,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  input  logic             rx_error,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] err_count,
  output logic             in_frame,
  output logic [7:0]       last_bad
);

  localparam int unsigned TIMER_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned LAST_IDX = 13;

  typedef enum logic {
    IDLE  = 1'b0,
    MATCH = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic               match_n;
  logic [CNT_W-1:0]   match_count_n, err_count_n;
  logic               in_frame_n;
  logic [7:0]         last_bad_n;
  logic               match_inc, err_inc;

  // Expected byte at each frame position
  function automatic logic [7:0] frame_rom(input logic [IDX_W-1:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = 8'h48; // H
      4'd1:    b = 8'h65; // e
      4'd2:    b = 8'h6C; // l
      4'd3:    b = 8'h6C; // l
      4'd4:    b = 8'h6F; // o
      4'd5:    b = 8'h20; // space
      4'd6:    b = 8'h57; // W
      4'd7:    b = 8'h6F; // o
      4'd8:    b = 8'h72; // r
      4'd9:    b = 8'h6C; // l
      4'd10:   b = 8'h64; // d
      4'd11:   b = 8'h21; // !
      4'd12:   b = 8'h0A; // LF
      4'd13:   b = 8'h0D; // CR
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      match       <= 1'b0;
      match_count <= '0;
      err_count   <= '0;
      in_frame    <= 1'b0;
      last_bad    <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      timer       <= timer_n;
      match       <= match_n;
      match_count <= match_count_n;
      err_count   <= err_count_n;
      in_frame    <= in_frame_n;
      last_bad    <= last_bad_n;
    end
  end

  // Next-state and next-output logic; rx_error overrides any byte in the same cycle
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    timer_n    = timer;
    match_n    = 1'b0;
    last_bad_n = last_bad;
    match_inc  = 1'b0;
    err_inc    = 1'b0;

    if (rx_error) begin
      err_inc = 1'b1;
      state_n = IDLE;
      idx_n   = '0;
      timer_n = '0;
    end else begin
      case (state)
        IDLE: begin
          timer_n = '0;
          if (rx_valid && (rx_byte == frame_rom(IDX_W'(0)))) begin
            idx_n   = IDX_W'(1);
            state_n = MATCH;
          end
        end
        MATCH: begin
          if (rx_valid) begin
            timer_n = '0;
            if (rx_byte == frame_rom(idx)) begin
              if (idx == IDX_W'(LAST_IDX)) begin
                match_n   = 1'b1;
                match_inc = 1'b1;
                state_n   = IDLE;
                idx_n     = '0;
              end else begin
                idx_n = idx + IDX_W'(1);
              end
            end else begin
              err_inc    = 1'b1;
              last_bad_n = rx_byte;
              // A stray 'H' is treated as the start of a new frame
              if (rx_byte == frame_rom(IDX_W'(0))) begin
                idx_n = IDX_W'(1);
              end else begin
                state_n = IDLE;
                idx_n   = '0;
              end
            end
          end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
            err_inc = 1'b1;
            state_n = IDLE;
            idx_n   = '0;
            timer_n = '0;
          end else begin
            timer_n = timer + TIMER_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          timer_n = '0;
        end
      endcase
    end

    match_count_n = match_count;
    if (match_inc && (match_count != {CNT_W{1'b1}})) begin
      match_count_n = match_count + CNT_W'(1);
    end
    err_count_n = err_count;
    if (err_inc && (err_count != {CNT_W{1'b1}})) begin
      err_count_n = err_count + CNT_W'(1);
    end
    in_frame_n = (state_n == MATCH);
  end

endmodule

// File: tb/tb_uart_msg_checker.sv
// Directed table-driven bench for uart_msg_checker (TIMEOUT_CYCLES=1000, CNT_W=4).
module tb_uart_msg_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_error = 1'b0;
  logic       match;
  logic [3:0] match_count;
  logic [3:0] err_count;
  logic       in_frame;
  logic [7:0] last_bad;

  uart_msg_checker #(.TIMEOUT_CYCLES(1000), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_error(rx_error), .match(match), .match_count(match_count),
    .err_count(err_count), .in_frame(in_frame), .last_bad(last_bad)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       e;
    int         gap;
    logic       em;
    logic [3:0] emc;
    logic [3:0] eec;
    logic       ein;
    logic [7:0] elb;
  } vec_t;

  vec_t       tbl[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] frame [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A, 8'h0D};

  // Compare all outputs against one expected record
  task automatic check(input string name, input logic em, input logic [3:0] emc,
                       input logic [3:0] eec, input logic ein, input logic [7:0] elb);
    n_vec++;
    if (match !== em || match_count !== emc || err_count !== eec ||
        in_frame !== ein || last_bad !== elb) begin
      n_bad++;
      $display("FAIL %s: got match=%b mc=%0d ec=%0d in_frame=%b last_bad=%h, want match=%b mc=%0d ec=%0d in_frame=%b last_bad=%h",
               name, match, match_count, err_count, in_frame, last_bad,
               em, emc, eec, ein, elb);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] b, input logic e,
                              input int gap, input logic em, input logic [3:0] emc,
                              input logic [3:0] eec, input logic ein, input logic [7:0] elb);
    vec_t t;
    t.v = v; t.b = b; t.e = e; t.gap = gap;
    t.em = em; t.emc = emc; t.eec = eec; t.ein = ein; t.elb = elb;
    return t;
  endfunction

  // Drive one cycle of inputs, check #1 after the edge, then idle for gap cycles
  task automatic apply(input vec_t t, input string name);
    @(negedge clk);
    rx_valid = t.v;
    rx_byte  = t.b;
    rx_error = t.e;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    check(name, t.em, t.emc, t.eec, t.ein, t.elb);
    repeat (t.gap) @(posedge clk);
  endtask

  task automatic run_table(input string name);
    foreach (tbl[i]) apply(tbl[i], $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  // Frame bytes start..stop; the byte at index 13 completes a frame
  task automatic add_seg(input int start, input int stop, input logic [3:0] mc_b,
                         input logic [3:0] mc_a, input logic [3:0] ec,
                         input logic [7:0] lb, input int gap);
    for (int i = start; i <= stop; i++) begin
      if (i == 13) tbl.push_back(mk(1'b1, frame[i], 1'b0, 0, 1'b1, mc_a, ec, 1'b0, lb));
      else         tbl.push_back(mk(1'b1, frame[i], 1'b0, gap, 1'b0, mc_b, ec, 1'b1, lb));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset", 1'b0, 4'd0, 4'd0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: good frame, 20 cycles apart; match is a single-cycle pulse
    add_seg(0, 13, 4'd0, 4'd1, 4'd0, 8'h00, 20);
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 5, 1'b0, 4'd1, 4'd0, 1'b0, 8'h00));
    run_table("t1_frame");

    // 2: "Hellx" mismatch, then a good frame
    add_seg(0, 3, 4'd1, 4'd1, 4'd0, 8'h00, 3);
    tbl.push_back(mk(1'b1, 8'h78, 1'b0, 3, 1'b0, 4'd1, 4'd1, 1'b0, 8'h78));
    add_seg(0, 13, 4'd1, 4'd2, 4'd1, 8'h78, 3);
    run_table("t2_mismatch");

    // 3: "HelH" resyncs on the stray H, then "ello World!\n\r" completes
    add_seg(0, 2, 4'd2, 4'd2, 4'd1, 8'h78, 3);
    tbl.push_back(mk(1'b1, 8'h48, 1'b0, 3, 1'b0, 4'd2, 4'd2, 1'b1, 8'h48));
    add_seg(1, 13, 4'd2, 4'd3, 4'd2, 8'h48, 3);
    run_table("t3_resync");

    // 4a: "Hel" then silence: still in frame after 999 cycles, timed out at 1000
    add_seg(0, 2, 4'd3, 4'd3, 4'd2, 8'h48, 0);
    run_table("t4a_hel");
    idle(999);
    check("t4a_before_timeout", 1'b0, 4'd3, 4'd2, 1'b1, 8'h48);
    idle(1);
    check("t4a_timeout", 1'b0, 4'd3, 4'd3, 1'b0, 8'h48);

    // 4b: next byte 999 cycles after 'l' -> no timeout
    add_seg(0, 2, 4'd3, 4'd3, 4'd3, 8'h48, 0);
    run_table("t4b_hel");
    idle(998);
    apply(mk(1'b1, 8'h6C, 1'b0, 0, 1'b0, 4'd3, 4'd3, 1'b1, 8'h48), "t4b_late_byte");
    // 4c: byte on the exact expiry cycle wins over the timeout
    idle(999);
    apply(mk(1'b1, 8'h6F, 1'b0, 0, 1'b0, 4'd3, 4'd3, 1'b1, 8'h48), "t4c_expiry_byte");
    add_seg(5, 13, 4'd3, 4'd4, 4'd3, 8'h48, 2);
    run_table("t4c_finish");

    // 5: rx_error with rx_valid mid-frame, then bytes ignored in IDLE, error in IDLE
    add_seg(0, 2, 4'd4, 4'd4, 4'd3, 8'h48, 2);
    tbl.push_back(mk(1'b1, 8'h6C, 1'b1, 2, 1'b0, 4'd4, 4'd4, 1'b0, 8'h48));
    tbl.push_back(mk(1'b1, 8'h6F, 1'b0, 2, 1'b0, 4'd4, 4'd4, 1'b0, 8'h48));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 2, 1'b0, 4'd4, 4'd5, 1'b0, 8'h48));
    add_seg(0, 2, 4'd4, 4'd4, 4'd5, 8'h48, 0);
    run_table("t5_error");
    // async reset mid-frame clears outputs without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_reset", 1'b0, 4'd0, 4'd0, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // without an 'H', the rest of the frame is ignored
    for (int i = 1; i <= 13; i++)
      tbl.push_back(mk(1'b1, frame[i], 1'b0, 1, 1'b0, 4'd0, 4'd0, 1'b0, 8'h00));
    run_table("t5_after_reset");

    // 6: 20 good frames saturate match_count at 15
    for (int k = 1; k <= 20; k++) begin
      add_seg(0, 13, 4'((k - 1 > 15) ? 15 : k - 1), 4'((k > 15) ? 15 : k),
              4'd0, 8'h00, 1);
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1, 1'b0, 4'((k > 15) ? 15 : k),
                       4'd0, 1'b0, 8'h00));
    end
    run_table("t6_saturate");
    // junk bytes in IDLE do not count as errors
    tbl.push_back(mk(1'b1, 8'h78, 1'b0, 1, 1'b0, 4'd15, 4'd0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 8'h0D, 1'b0, 1, 1'b0, 4'd15, 4'd0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 8'h65, 1'b0, 1, 1'b0, 4'd15, 4'd0, 1'b0, 8'h00));
    run_table("t6_junk");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
